// File: rtl/tick_timer_pkg.sv
// tick_timer_pkg: shared state encoding and widths for tick_timer.
package tick_timer_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;
    localparam int EXPIRE_CNT_W = 8;
endpackage

// File: rtl/tick_timer.sv
// tick_timer: tick-driven countdown timer with one-shot/periodic modes and pause/resume.
// Optional saturating expiry counter output enabled by TICK_TIMER_EXPIRE_CNT_EN.
module tick_timer
    import tick_timer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    tick,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    clear,
    input  logic                    periodic,
    input  logic [WIDTH-1:0]        load_value,
    output logic [WIDTH-1:0]        count,
    output logic                    running,
    output logic                    expired,
`ifdef TICK_TIMER_EXPIRE_CNT_EN
    output logic [EXPIRE_CNT_W-1:0] expire_cnt,
`endif
    output state_t                  state
);
    state_t           state_n;
    logic [WIDTH-1:0] count_n, reload_q, reload_n;
    logic             periodic_q, periodic_n, expired_n;

    always_comb begin
        state_n    = state;
        count_n    = count;
        reload_n   = reload_q;
        periodic_n = periodic_q;
        expired_n  = 1'b0;
        if (clear) begin
            state_n = IDLE;
            count_n = '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    count_n = '0;
                    if (!stop && start) begin
                        reload_n   = load_value;
                        periodic_n = periodic;
                        count_n    = load_value;
                        // a zero load expires immediately without waiting for a tick
                        state_n    = (load_value == '0) ? DONE : RUN;
                        expired_n  = (load_value == '0);
                    end
                end
                RUN: begin
                    if (stop)
                        state_n = PAUSE;
                    else if (tick) begin
                        if (count > WIDTH'(1))
                            count_n = count - WIDTH'(1);
                        else begin
                            expired_n = 1'b1;
                            count_n   = periodic_q ? reload_q : '0;
                            state_n   = periodic_q ? RUN : DONE;
                        end
                    end
                end
                PAUSE: state_n = (!stop && start) ? RUN : PAUSE;
                default: begin
                    state_n = IDLE;
                    count_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            count      <= '0;
            reload_q   <= '0;
            periodic_q <= 1'b0;
            running    <= 1'b0;
            expired    <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            reload_q   <= reload_n;
            periodic_q <= periodic_n;
            running    <= (state_n == RUN);
            expired    <= expired_n;
        end
    end

`ifdef TICK_TIMER_EXPIRE_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            expire_cnt <= '0;
        else if (clear)
            expire_cnt <= '0;
        else if (expired_n && expire_cnt != '1)
            expire_cnt <= expire_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_tick_timer.sv
// tb_tick_timer: directed stimulus with an expiry scoreboard for tick_timer.
// Build with TICK_TIMER_EXPIRE_CNT_EN defined to also exercise expire_cnt.
module tb_tick_timer;
    import tick_timer_pkg::*;

    typedef struct {
        logic [15:0] count;
        state_t      st;
        logic        running;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, periodic = 1'b0;
    logic [15:0] load_value = '0;
    logic [15:0] count;
    logic        running, expired;
    state_t      state;
`ifdef TICK_TIMER_EXPIRE_CNT_EN
    logic [EXPIRE_CNT_W-1:0] expire_cnt;
`endif

    int   passed = 0;
    int   total = 0;
    exp_t sb[$];

    tick_timer #(.WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .start(start), .stop(stop),
        .clear(clear), .periodic(periodic), .load_value(load_value),
        .count(count), .running(running), .expired(expired),
`ifdef TICK_TIMER_EXPIRE_CNT_EN
        .expire_cnt(expire_cnt),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    task automatic push(input logic [15:0] c, input state_t s, input logic r);
        exp_t e;
        e.count = c; e.st = s; e.running = r;
        sb.push_back(e);
    endtask

    // every expired pulse must match the oldest expected expiry
    always @(negedge clk) begin
        if (reset_n && expired) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_expired: got pulse expected none at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("exp_count", 32'(count), 32'(e.count));
                chk("exp_state", 32'(state), 32'(e.st));
                chk("exp_running", 32'(running), 32'(e.running));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_tick();
        tick = 1'b1; cyc(1); tick = 1'b0; cyc(3);
    endtask

    task automatic do_start(input logic [15:0] v, input logic p);
        load_value = v; periodic = p; start = 1'b1; cyc(1); start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1; cyc(1); clear = 1'b0;
    endtask

    task automatic chk_st(input string name, input logic [15:0] c, input state_t s);
        chk({name, "_count"}, 32'(count), 32'(c));
        chk({name, "_state"}, 32'(state), 32'(s));
        chk({name, "_running"}, 32'(running), 32'(s == RUN));
    endtask

    initial begin
        int exp2[9] = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
        cyc(2);
        chk_st("reset", 16'd0, IDLE);
        chk("reset_expired", 32'(expired), 32'd0);
        reset_n = 1'b1;
        cyc(1);

        // one-shot 5
        do_start(16'd5, 1'b0);
        chk_st("os_load", 16'd5, RUN);
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) push(16'd0, DONE, 1'b0);
            do_tick();
            chk_st("os_tick", 16'(5 - k), (k == 5) ? DONE : RUN);
        end

        // periodic 3
        do_start(16'd3, 1'b1);
        chk_st("per_load", 16'd3, RUN);
        for (int k = 1; k <= 9; k++) begin
            if (k % 3 == 0) push(16'd3, RUN, 1'b1);
            do_tick();
            chk_st("per_tick", 16'(exp2[k-1]), RUN);
        end
        do_clear();
        chk_st("per_clear", 16'd0, IDLE);

        // pause / resume
        do_start(16'd10, 1'b0);
        repeat (4) do_tick();
        chk_st("pr_run", 16'd6, RUN);
        stop = 1'b1; cyc(1); stop = 1'b0;
        chk_st("pr_pause", 16'd6, PAUSE);
        repeat (5) do_tick();
        chk_st("pr_hold", 16'd6, PAUSE);
        start = 1'b1; cyc(1); start = 1'b0;
        chk_st("pr_resume", 16'd6, RUN);
        for (int k = 1; k <= 6; k++) begin
            if (k == 6) push(16'd0, DONE, 1'b0);
            do_tick();
        end
        chk_st("pr_done", 16'd0, DONE);

        // priority
        do_start(16'd3, 1'b0);
        do_tick();
        chk_st("pri_pre", 16'd2, RUN);
        stop = 1'b1; tick = 1'b1; cyc(1); stop = 1'b0; tick = 1'b0;
        chk_st("pri_stop_tick", 16'd2, PAUSE);
        clear = 1'b1; start = 1'b1; cyc(1); clear = 1'b0; start = 1'b0;
        chk_st("pri_clear_start", 16'd0, IDLE);

        // zero load expires without a tick
        push(16'd0, DONE, 1'b0);
        do_start(16'd0, 1'b0);
        chk_st("zero_load", 16'd0, DONE);
        cyc(2);

        // reload of 1 with back-to-back ticks: one pulse per tick
        do_start(16'd1, 1'b1);
        chk_st("one_load", 16'd1, RUN);
        repeat (3) push(16'd1, RUN, 1'b1);
        tick = 1'b1; cyc(3); tick = 1'b0; cyc(1);
        chk_st("one_after", 16'd1, RUN);
        do_clear();

        // asynchronous reset mid-run
        do_start(16'd7, 1'b0);
        do_tick();
        chk_st("rst_pre", 16'd6, RUN);
        #2 reset_n = 1'b0;
        #1;
        chk_st("rst_async", 16'd0, IDLE);
        chk("rst_expired", 32'(expired), 32'd0);
        cyc(1);
        reset_n = 1'b1;
        cyc(1);

`ifdef TICK_TIMER_EXPIRE_CNT_EN
        do_start(16'd1, 1'b1);
        repeat (300) push(16'd1, RUN, 1'b1);
        tick = 1'b1; cyc(300); tick = 1'b0; cyc(1);
        chk("cnt_sat", 32'(expire_cnt), 32'd255);
        do_clear();
        chk("cnt_clear", 32'(expire_cnt), 32'd0);
`endif

        cyc(3);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end
endmodule
